// File: rtl/iopmp_entry_walker.sv
// -----------------------------------------------------------------------------
// iopmp_entry_walker
//   Reader side of the IOPMP entry-table RAM. Accepts one access-check request,
//   walks entries [start..end] in priority order through the RAM read port
//   (1-cycle latency), decodes each 128-bit entry and applies first-match PMP
//   rules. Returns allow/deny, an error code and the matching entry index.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_*                  check request (valid/ready), latched at accept
//   ram_ena_o/ram_raddr_o  RAM read request; ram_dout_i valid the next cycle
//   rsp_*                  result (valid/ready), held until rsp_ready_i
//   perf_walks_o           accepted requests (optional counter)
//   perf_denies_o          handshaken responses with allow=0 (optional counter)
//
// Configuration
//   IOPMP_WALKER_PERF_EN   when defined, the two perf ports are 32-bit
//                          saturating counters; otherwise they are tied to 0.
//
// Entry word layout: [63:0] W (address >> 2), [64] r, [65] w, [66] x,
//                    [68:67] A (0 OFF, 1 TOR, 2 NA4, 3 NAPOT).
// -----------------------------------------------------------------------------
module iopmp_entry_walker #(
   parameter int DEPTH      = 32,
   parameter int IDX_W      = $clog2(DEPTH),
   parameter int DATA_WIDTH = 128
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [63:0]           req_addr_i,
   input  logic [1:0]            req_size_i,
   input  logic [2:0]            req_perm_i,
   input  logic [IDX_W-1:0]      req_start_i,
   input  logic [IDX_W-1:0]      req_end_i,
   output logic                  ram_ena_o,
   output logic [IDX_W-1:0]      ram_raddr_o,
   input  logic [DATA_WIDTH-1:0] ram_dout_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic                  rsp_allow_o,
   output logic [1:0]            rsp_err_o,
   output logic [IDX_W-1:0]      rsp_idx_o,
   output logic [31:0]           perf_walks_o,
   output logic [31:0]           perf_denies_o
);

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_NOHIT   = 2'd1;
   localparam logic [1:0] ERR_PARTIAL = 2'd2;
   localparam logic [1:0] ERR_PERM    = 2'd3;

   localparam logic [1:0] A_TOR   = 2'd1;
   localparam logic [1:0] A_NA4   = 2'd2;
   localparam logic [1:0] A_NAPOT = 2'd3;

   typedef enum logic [1:0] {IDLE, PRIME, WALK, RESP} state_t;

   state_t           state;
   logic [63:0]      lat_addr;
   logic [1:0]       lat_size;
   logic [2:0]       lat_perm;
   logic [IDX_W-1:0] lat_start;
   logic [IDX_W-1:0] lat_end;
   logic [63:0]      prev;       // W of the previously checked entry (TOR base)
   logic             prev_pend;  // dout holds the PRIME read of start-1
   logic             chk_vld;    // dout holds entry chk_idx, to be checked now
   logic [IDX_W-1:0] chk_idx;

   logic accept;
   logic hs;
   assign accept = req_valid_i & req_ready_o;
   assign hs     = rsp_valid_o & rsp_ready_i;

   // ---------------------------------------------------------------------------
   // Entry decode and range match on the current RAM word.
   // All bounds are byte addresses in 67 bits so that top-of-space regions
   // (NAPOT covering everything, top = 2^66) never wrap.
   // ---------------------------------------------------------------------------
   logic [63:0] ent_w;
   logic [2:0]  ent_xwr;
   logic [1:0]  ent_a;
   logic [63:0] napot_m;
   logic [66:0] lo, hi, base, top;
   logic        rgn_ok, full_hit, part_hit, perm_ok;

   assign ent_w   = ram_dout_i[63:0];
   assign ent_xwr = ram_dout_i[66:64];
   assign ent_a   = ram_dout_i[68:67];

   logic unused_dout;
   assign unused_dout = ^ram_dout_i[DATA_WIDTH-1:69];

   always_comb begin
      lo      = {3'b000, lat_addr};
      hi      = lo + (67'd1 << lat_size);
      // W ^ (W+1) sets the trailing ones plus the first zero: 2^(t+1)-1.
      // All-ones W wraps to an all-ones mask, giving base 0 / size 2^66.
      napot_m = ent_w ^ (ent_w + 64'd1);
      base    = '0;
      top     = '0;
      rgn_ok  = 1'b0;
      case (ent_a)
         A_TOR: begin
            base   = {1'b0, prev, 2'b00};
            top    = {1'b0, ent_w, 2'b00};
            rgn_ok = (prev < ent_w);
         end
         A_NA4: begin
            base   = {1'b0, ent_w, 2'b00};
            top    = base + 67'd4;
            rgn_ok = 1'b1;
         end
         A_NAPOT: begin
            base   = {1'b0, ent_w & ~napot_m, 2'b00};
            top    = base + (({3'b000, napot_m} + 67'd1) << 2);
            rgn_ok = 1'b1;
         end
         default: ;
      endcase
      full_hit = rgn_ok && (lo >= base) && (hi <= top);
      part_hit = rgn_ok && (lo < top) && (hi > base) && !full_hit;
      perm_ok  = |(lat_perm & ent_xwr);
   end

   // ---------------------------------------------------------------------------
   // Walk FSM. ram_ena_o/ram_raddr_o describe the read issued this cycle; the
   // read issued last cycle (chk_vld/chk_idx) is checked against ram_dout_i.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         req_ready_o <= 1'b1;
         ram_ena_o   <= 1'b0;
         ram_raddr_o <= '0;
         rsp_valid_o <= 1'b0;
         rsp_allow_o <= 1'b0;
         rsp_err_o   <= ERR_NONE;
         rsp_idx_o   <= '0;
         lat_addr    <= '0;
         lat_size    <= '0;
         lat_perm    <= '0;
         lat_start   <= '0;
         lat_end     <= '0;
         prev        <= '0;
         prev_pend   <= 1'b0;
         chk_vld     <= 1'b0;
         chk_idx     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  req_ready_o <= 1'b0;
                  lat_addr    <= req_addr_i;
                  lat_size    <= req_size_i;
                  lat_perm    <= req_perm_i;
                  lat_start   <= req_start_i;
                  lat_end     <= req_end_i;
                  prev        <= '0;
                  prev_pend   <= 1'b0;
                  chk_vld     <= 1'b0;
                  if ((req_start_i > req_end_i) ||
                      ({1'b0, req_end_i} >= (IDX_W+1)'(DEPTH))) begin
                     // empty or out-of-table range: answer without reading
                     state       <= RESP;
                     rsp_valid_o <= 1'b1;
                     rsp_allow_o <= 1'b0;
                     rsp_err_o   <= ERR_NOHIT;
                     rsp_idx_o   <= '0;
                  end else if (req_start_i != '0) begin
                     state       <= PRIME;
                     ram_ena_o   <= 1'b1;
                     ram_raddr_o <= req_start_i - IDX_W'(1);
                  end else begin
                     state       <= WALK;
                     ram_ena_o   <= 1'b1;
                     ram_raddr_o <= req_start_i;
                  end
               end
            end

            PRIME: begin
               // start-1 is being read now; its W lands in the first WALK cycle
               state       <= WALK;
               ram_raddr_o <= lat_start;
               prev_pend   <= 1'b1;
            end

            WALK: begin
               chk_vld <= ram_ena_o;
               chk_idx <= ram_raddr_o;
               if (prev_pend) begin
                  prev      <= ent_w;
                  prev_pend <= 1'b0;
               end
               if (chk_vld) prev <= ent_w;

               if (chk_vld && (full_hit || part_hit)) begin
                  // first match wins; the read issued this cycle is dropped
                  state       <= RESP;
                  ram_ena_o   <= 1'b0;
                  chk_vld     <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  rsp_idx_o   <= chk_idx;
                  rsp_allow_o <= full_hit && perm_ok;
                  rsp_err_o   <= part_hit ? ERR_PARTIAL :
                                 perm_ok  ? ERR_NONE : ERR_PERM;
               end else if (chk_vld && (chk_idx == lat_end)) begin
                  state       <= RESP;
                  ram_ena_o   <= 1'b0;
                  chk_vld     <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  rsp_idx_o   <= '0;
                  rsp_allow_o <= 1'b0;
                  rsp_err_o   <= ERR_NOHIT;
               end else if (ram_ena_o && (ram_raddr_o != lat_end)) begin
                  ram_raddr_o <= ram_raddr_o + IDX_W'(1);
               end else begin
                  // last entry issued: wait for its check without reading past it
                  ram_ena_o <= 1'b0;
               end
            end

            RESP: begin
               if (hs) begin
                  state       <= IDLE;
                  rsp_valid_o <= 1'b0;
                  req_ready_o <= 1'b1;
               end
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Optional performance counters
   // ---------------------------------------------------------------------------
`ifdef IOPMP_WALKER_PERF_EN
   logic [31:0] walks_q;
   logic [31:0] denies_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         walks_q  <= '0;
         denies_q <= '0;
      end else begin
         if (accept && (walks_q != 32'hFFFF_FFFF))
            walks_q <= walks_q + 32'd1;
         if (hs && !rsp_allow_o && (denies_q != 32'hFFFF_FFFF))
            denies_q <= denies_q + 32'd1;
      end
   end

   assign perf_walks_o  = walks_q;
   assign perf_denies_o = denies_q;
`else
   assign perf_walks_o  = '0;
   assign perf_denies_o = '0;
`endif

endmodule

// File: tb/tb_iopmp_entry_walker.sv
module tb_iopmp_entry_walker;
   localparam int DEPTH = 32;
   localparam int IDX_W = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [63:0]      req_addr = '0;
   logic [1:0]       req_size = '0;
   logic [2:0]       req_perm = '0;
   logic [IDX_W-1:0] req_start = '0;
   logic [IDX_W-1:0] req_end = '0;
   logic             ram_ena;
   logic [IDX_W-1:0] ram_raddr;
   logic [127:0]     ram_dout = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic             rsp_allow;
   logic [1:0]       rsp_err;
   logic [IDX_W-1:0] rsp_idx;
   logic [31:0]      perf_walks;
   logic [31:0]      perf_denies;

   int errors = 0;
   int checks = 0;
   int m_walks = 0;
   int m_denies = 0;

   always #5 clk = ~clk;

   iopmp_entry_walker #(.DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_addr_i(req_addr), .req_size_i(req_size), .req_perm_i(req_perm),
      .req_start_i(req_start), .req_end_i(req_end),
      .ram_ena_o(ram_ena), .ram_raddr_o(ram_raddr), .ram_dout_i(ram_dout),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_allow_o(rsp_allow), .rsp_err_o(rsp_err), .rsp_idx_o(rsp_idx),
      .perf_walks_o(perf_walks), .perf_denies_o(perf_denies)
   );

   // entry table RAM, 1-cycle read latency
   logic [127:0] mem [DEPTH];
   always @(posedge clk) if (ram_ena) ram_dout <= mem[ram_raddr];

   // read monitor (cumulative; tests compare snapshots)
   int ena_total = 0;
   int rd_cnt [DEPTH] = '{default: 0};
   always @(posedge clk) begin
      if (!rst && ram_ena) begin
         ena_total <= ena_total + 1;
         rd_cnt[ram_raddr] <= rd_cnt[ram_raddr] + 1;
      end
   end

   int rd_snap [DEPTH];
   int ena_snap;

   function automatic logic [127:0] ent(input logic [63:0] w, input logic [2:0] xwr,
                                        input logic [1:0] a);
      return {59'd0, a, xwr, w};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
   endtask

   // Reference: first-match PMP walk written straight from the rules.
   function automatic void ref_model(input logic [63:0] addr, input logic [1:0] size,
                                     input logic [2:0] perm, input int st, input int en,
                                     output logic allow, output logic [1:0] err,
                                     output int idx, output int lat);
      logic [66:0] lo, hi, base, top;
      logic [63:0] prev, w;
      bit ok, full, part;
      int t;
      allow = 1'b0; err = 2'd1; idx = 0; lat = 0;
      if (st > en) return;
      lo = 67'(addr);
      hi = lo + (67'd1 << size);
      prev = (st == 0) ? 64'd0 : mem[st-1][63:0];
      for (int i = st; i <= en; i++) begin
         w = mem[i][63:0];
         ok = 1; base = '0; top = '0;
         case (mem[i][68:67])
            2'd0: ok = 0;
            2'd1: begin ok = (prev < w); base = 67'(prev) * 4; top = 67'(w) * 4; end
            2'd2: begin base = 67'(w) * 4; top = base + 4; end
            default: begin
               t = 0;
               while (t < 64 && w[t]) t++;
               if (t == 64) begin
                  base = '0; top = 67'd1 << 66;
               end else begin
                  base = (67'(w) >> (t + 1)) << (t + 3);
                  top  = base + (67'd1 << (t + 3));
               end
            end
         endcase
         full = ok && lo >= base && hi <= top;
         part = ok && lo < top && hi > base && !full;
         if (full || part) begin
            idx = i;
            lat = ((st > 0) ? 1 : 0) + (i - st) + 2;
            if (full) begin
               allow = |(perm & mem[i][66:64]);
               err = allow ? 2'd0 : 2'd3;
            end else begin
               err = 2'd2;
            end
            return;
         end
         prev = w;
      end
      lat = ((st > 0) ? 1 : 0) + (en - st) + 2;
   endfunction

   // One full transaction: request, wait for response, check, optional
   // back-pressure for `hold` cycles, then handshake.
   task automatic run(input string tag, input logic [63:0] addr, input logic [1:0] size,
                      input logic [2:0] perm, input int st, input int en, input int hold);
      logic e_allow;
      logic [1:0] e_err;
      int e_idx, e_lat, n;
      ref_model(addr, size, perm, st, en, e_allow, e_err, e_idx, e_lat);
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      chk({tag, ".req_ready"}, 64'(req_ready), 64'd1);
      rd_snap  = rd_cnt;
      ena_snap = ena_total;
      req_valid = 1'b1; req_addr = addr; req_size = size; req_perm = perm;
      req_start = IDX_W'(st); req_end = IDX_W'(en);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
      chk({tag, ".valid"}, 64'(rsp_valid), 64'd1);
      chk({tag, ".latency"}, 64'(n), 64'(e_lat));
      chk({tag, ".allow"}, 64'(rsp_allow), 64'(e_allow));
      chk({tag, ".err"}, 64'(rsp_err), 64'(e_err));
      chk({tag, ".idx"}, 64'(rsp_idx), 64'(e_idx));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk({tag, ".hold_valid"}, 64'(rsp_valid), 64'd1);
         chk({tag, ".hold_bits"}, 64'({rsp_allow, rsp_err, rsp_idx}),
             64'({e_allow, e_err, IDX_W'(e_idx)}));
         chk({tag, ".hold_noready"}, 64'(req_ready), 64'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, ".rsp_drop"}, 64'(rsp_valid), 64'd0);
      chk({tag, ".ready_again"}, 64'(req_ready), 64'd1);
      m_walks++;
      if (!e_allow) m_denies++;
   endtask

   task automatic check_perf(input string tag);
`ifdef IOPMP_WALKER_PERF_EN
      chk({tag, ".walks"}, 64'(perf_walks), 64'(m_walks));
      chk({tag, ".denies"}, 64'(perf_denies), 64'(m_denies));
`else
      chk({tag, ".walks"}, 64'(perf_walks), 64'd0);
      chk({tag, ".denies"}, 64'(perf_denies), 64'd0);
`endif
   endtask

   initial begin
      logic [63:0] w, msk, addr;
      int a, k, st, en;
      clear_mem();

      // ---- reset state
      repeat (3) @(negedge clk);
      chk("rst.req_ready", 64'(req_ready), 64'd1);
      chk("rst.ram_ena", 64'(ram_ena), 64'd0);
      chk("rst.raddr", 64'(ram_raddr), 64'd0);
      chk("rst.rsp", 64'({rsp_valid, rsp_allow, rsp_err, rsp_idx}), 64'd0);
      check_perf("rst.perf");
      rst = 1'b0;
      @(negedge clk);

      // ---- 1 NAPOT 8 KiB at 0x8000_0000, read allowed
      mem[0] = ent(64'h2000_03FF, 3'b001, 2'd3);
      run("napot", 64'h8000_1000, 2'd3, 3'b001, 0, 0, 0);
      chk("napot.rsp_allow_direct", 64'(m_denies), 64'd0);

      // ---- 2 TOR [0x1000,0x2000) write-only, base from PRIME read of entry 1
      clear_mem();
      mem[1] = ent(64'h400, 3'b001, 2'd0);
      mem[2] = ent(64'h800, 3'b010, 2'd1);
      run("tor_rd", 64'h1800, 2'd2, 3'b001, 2, 2, 0);
      chk("tor.prime_read", 64'(rd_cnt[1] - rd_snap[1]), 64'd1);
      run("tor_wr", 64'h1800, 2'd2, 3'b010, 2, 2, 0);

      // ---- 3 partial hit on NA4; later whole-space entries must not matter
      clear_mem();
      mem[0] = ent(64'h100, 3'b111, 2'd2);
      for (int i = 1; i < 6; i++) mem[i] = ent('1, 3'b111, 2'd3);
      run("partial", 64'h400, 2'd3, 3'b001, 0, 5, 0);
      for (int i = 2; i < 6; i++) chk("partial.no_read", 64'(rd_cnt[i] - rd_snap[i]), 64'd0);

      // ---- 4 priority: entry 3 denies before entry 5 allows; held 10 cycles
      clear_mem();
      mem[3] = ent(64'h100, 3'b001, 2'd2);
      mem[5] = ent('1, 3'b111, 2'd3);
      run("prio", 64'h400, 2'd2, 3'b010, 0, 7, 10);
      run("prio_off", 64'h400, 2'd2, 3'b010, 0, 2, 0);

      // ---- 5 bounds
      run("empty", 64'h400, 2'd0, 3'b001, 5, 4, 0);
      chk("empty.no_ena", 64'(ena_total - ena_snap), 64'd0);
      clear_mem();
      run("all_off", 64'h400, 2'd0, 3'b001, 0, DEPTH-1, 0);

      // ---- top-of-space arithmetic
      mem[0] = ent('1, 3'b001, 2'd3);
      run("whole", 64'hFFFF_FFFF_FFFF_FFF8, 2'd3, 3'b001, 0, 0, 0);
      clear_mem();
      mem[0] = ent('1, 3'b100, 2'd1);
      run("tor_top", 64'hFFFF_FFFF_FFFF_FFF8, 2'd3, 3'b100, 0, 0, 0);
      check_perf("mid.perf");

      // ---- 6 reset mid-walk, busy request ignored
      clear_mem();
      req_valid = 1'b1; req_addr = 64'h40; req_size = 2'd0; req_perm = 3'b001;
      req_start = '0; req_end = IDX_W'(DEPTH-1);
      @(negedge clk);
      req_start = IDX_W'(7);
      repeat (5) @(negedge clk);
      chk("busy.ready", 64'(req_ready), 64'd0);
      chk("busy.walking", 64'(ram_ena), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rstw.req_ready", 64'(req_ready), 64'd1);
      chk("rstw.ram", 64'({ram_ena, ram_raddr}), 64'd0);
      chk("rstw.rsp", 64'({rsp_valid, rsp_allow, rsp_err, rsp_idx}), 64'd0);
      m_walks = 0; m_denies = 0;
      check_perf("rstw.perf");
      rst = 1'b0;
      @(negedge clk);
      chk("rstw.idle", 64'({req_ready, rsp_valid}), 64'b10);

      // three denies after reset
      run("deny0", 64'h40, 2'd0, 3'b001, 0, 3, 0);
      run("deny1", 64'h40, 2'd0, 3'b010, 4, 2, 0);
      mem[1] = ent(64'h10, 3'b001, 2'd2);
      run("deny2", 64'h40, 2'd0, 3'b100, 0, 3, 2);
      check_perf("deny.perf");

      // ---- randomized tables and requests
      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < DEPTH; i++) begin
            a = $urandom_range(0, 5);
            w = 64'($urandom_range(0, 4095));
            if (a == 3) begin
               k = $urandom_range(0, 6);
               msk = (64'd1 << (k + 1)) - 64'd1;
               w = (w & ~msk) | (msk >> 1);
            end
            mem[i] = ent(w, 3'($urandom_range(0, 7)), (a > 3) ? 2'd0 : 2'(a));
         end
         addr = 64'($urandom_range(0, 'h3FF8));
         st = $urandom_range(0, DEPTH-1);
         if (st > 0 && $urandom_range(0, 7) == 0) en = st - 1;
         else en = $urandom_range(st, DEPTH-1);
         run("rand", addr, 2'($urandom_range(0, 3)), 3'b001 << $urandom_range(0, 2),
             st, en, $urandom_range(0, 2));
      end
      check_perf("end.perf");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
